// File: rtl/instruction_issuer_pkg.sv
// Shared constants for the instruction issuer and the decoder that consumes its words.
package instruction_issuer_pkg;
    localparam int ADDR_W     = 13;
    localparam int INSTR_W    = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_PTR_W = 2;
    localparam int FIFO_CNT_W = 3;

    localparam logic [2:0] OP_LOAD_ADDR   = 3'b000;
    localparam logic [2:0] OP_LOAD_WEIGHT = 3'b001;
    localparam logic [2:0] OP_HALT        = 3'b111;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op == OP_LOAD_ADDR) || (op == OP_LOAD_WEIGHT) || (op == OP_HALT);
    endfunction
endpackage

// File: rtl/instruction_issuer_fifo.sv
// instr_fifo: 4-entry instruction FIFO; push and pop may coincide even when full.
module instr_fifo
    import instruction_issuer_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [INSTR_W-1:0]    push_data,
    input  logic                  pop,
    output logic [INSTR_W-1:0]    pop_data,
    output logic                  full,
    output logic                  empty,
    output logic [FIFO_CNT_W-1:0] count
);
    logic [INSTR_W-1:0]    mem [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] wr_ptr;
    logic [FIFO_PTR_W-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full     = (count == FIFO_CNT_W'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A push into a full FIFO lands in the slot the simultaneous pop is vacating.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/instruction_issuer.sv
// Fetches a program from instruction memory and streams it to the decoder.
// Optional opcode checking (illegal_op port) is enabled by ISSUER_OPCODE_CHECK_EN.
module instruction_issuer
    import instruction_issuer_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  prog_base,
    input  logic [ADDR_W-1:0]  prog_len,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_rvalid,
    output logic [INSTR_W-1:0] instruction,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               busy,
    output logic               done,
`ifdef ISSUER_OPCODE_CHECK_EN
    output logic               illegal_op,
`endif
    output logic [1:0]         fsm_state
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state;
    logic [ADDR_W-1:0]     base_q;
    logic [ADDR_W-1:0]     len_q;
    logic [ADDR_W-1:0]     fetch_cnt;
    logic                  outstanding;
    logic                  rsp;
    logic                  rsp_bad;
    logic                  rsp_halt;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FIFO_CNT_W-1:0] fifo_count;

    // Handshake: a word moves to the decoder in any cycle where instr_valid and
    // instr_ready are both 1; instruction is held unchanged until that happens.
    assign rsp      = imem_rvalid && outstanding;
    assign rsp_halt = rsp && (imem_rdata[15:13] == OP_HALT);
`ifdef ISSUER_OPCODE_CHECK_EN
    assign rsp_bad  = rsp && !is_legal_op(imem_rdata[15:13]);
`else
    assign rsp_bad  = 1'b0;
`endif
    assign pop         = instr_valid && instr_ready;
    assign instr_valid = !fifo_empty;
    assign imem_req    = (state == S_FETCH) && !outstanding && (fetch_cnt < len_q)
                         && ((fifo_count + {2'b00, outstanding}) < FIFO_CNT_W'(FIFO_DEPTH));
    assign imem_addr   = imem_req ? (base_q + fetch_cnt) : '0;
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);
    assign fsm_state   = state;

    instr_fifo u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rsp && !rsp_bad),
        .push_data (imem_rdata),
        .pop       (pop),
        .pop_data  (instruction),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            base_q      <= '0;
            len_q       <= '0;
            fetch_cnt   <= '0;
            outstanding <= 1'b0;
        end else begin
            if (imem_req) begin
                outstanding <= 1'b1;
                fetch_cnt   <= fetch_cnt + 1'b1;
            end else if (rsp) begin
                outstanding <= 1'b0;
            end
            case (state)
                S_IDLE: if (start) begin
                    base_q    <= prog_base;
                    len_q     <= prog_len;
                    fetch_cnt <= '0;
                    state     <= (prog_len == '0) ? S_DONE : S_FETCH;
                end
                S_FETCH: if (rsp_halt || rsp_bad || (fetch_cnt == len_q)) state <= S_DRAIN;
                S_DRAIN: if (fifo_empty && !outstanding) state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ISSUER_OPCODE_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                         illegal_op <= 1'b0;
        else if (state == S_IDLE && start)  illegal_op <= 1'b0;
        else if (rsp_bad)                   illegal_op <= 1'b1;
    end
`endif
endmodule

// File: doc/instruction_issuer.md
INSTRUCTION_ISSUER -- requirements
Module: instruction_issuer

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have port start, input, 1: one-cycle pulse that launches a program; ignored while busy=1.
REQ-004 SHALL have port prog_base, input, 13: first instruction-memory address, sampled when start is accepted.
REQ-005 SHALL have port prog_len, input, 13: instruction count, sampled when start is accepted.
REQ-006 SHALL have port imem_req, output, 1: one-cycle read request.
REQ-007 SHALL have port imem_addr, output, 13: read address, valid while imem_req=1.
REQ-008 SHALL have port imem_rdata, input, 16: read data, valid while imem_rvalid=1.
REQ-009 SHALL have port imem_rvalid, input, 1: read response, arriving one or more cycles after imem_req.
REQ-010 SHALL have port instruction, output, 16: word issued to the decoder (opcode [15:13], operand [12:0]).
REQ-011 SHALL have port instr_valid, output, 1: instruction holds a valid word.
REQ-012 SHALL have port instr_ready, input, 1: decoder accepts the word; a transfer occurs when instr_valid=1 and instr_ready=1 in the same cycle.
REQ-013 SHALL have port busy, output, 1: high from start acceptance through the done cycle.
REQ-014 SHALL have port done, output, 1: one-cycle pulse at program completion.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, DRAIN, DONE: IDLE->FETCH on start; FETCH->DRAIN once fetch count = prog_len or a HALT word (opcode 3'b111) is received; DRAIN->DONE when the FIFO is empty and no read is outstanding; DONE->IDLE after one cycle.
REQ-016 SHALL go IDLE->DONE directly when start is accepted with prog_len=0, issuing no reads.
REQ-017 SHALL allow at most one read outstanding; imem_req asserts only in FETCH, with no read outstanding, fetch count < prog_len, and (FIFO occupancy + outstanding) < 4.
REQ-018 SHALL drive imem_addr = (prog_base + fetch count) mod 2^13; addresses wrap from 13'h1FFF to 0.
REQ-019 SHALL push imem_rdata into a 4-entry FIFO on imem_rvalid; imem_rvalid with no read outstanding SHALL be ignored.
REQ-020 SHALL issue the HALT word downstream, then fetch nothing further.
REQ-021 SHALL drive instr_valid = FIFO not empty, with instruction = FIFO head, held stable until transferred.
REQ-022 SHALL permit push and pop in the same cycle, including when the FIFO is full, with occupancy unchanged.
REQ-023 SHALL assert done for exactly one cycle in DONE; busy=0 only in IDLE.

Reset
REQ-024 SHALL, on reset=0 at any time including mid-program, immediately clear the FSM to IDLE, the FIFO to empty, and the counters and outstanding flag to 0, and drive imem_req=0, instr_valid=0, busy=0, done=0, imem_addr=0, instruction=0.
REQ-025 SHALL ignore a read response that arrives after reset for a request issued before reset.

Configuration
REQ-026 SHALL, with ISSUER_OPCODE_CHECK_EN defined, treat any received opcode other than 3'b000, 3'b001 or 3'b111 as illegal: drop the word, set a sticky output illegal_op (1 bit, cleared by reset or accepted start), and move to DRAIN.
REQ-027 SHALL, without ISSUER_OPCODE_CHECK_EN, have no illegal_op port and pass all opcodes through unchanged.

Structure
REQ-028 SHALL place opcode constants (LOAD_ADDR=3'b000, LOAD_WEIGHT=3'b001, HALT=3'b111), the 13-bit address width, the 16-bit instruction width and FIFO depth 4 in the shared package that the decoder also uses.
REQ-029 SHALL implement the FIFO as the sub-module instr_fifo (16-bit data, depth 4, full/empty outputs).

Verification
REQ-030 SHALL cover: start with prog_base=0x010, prog_len=3, 1-cycle memory latency, instr_ready=1 -> reads at 0x010, 0x011, 0x012; three words issued in order; one done pulse.
REQ-031 SHALL cover: prog_len=5, instr_ready=0 for 20 cycles -> exactly 4 reads issued; instruction stable; remaining read and issue follow once ready rises.
REQ-032 SHALL cover: prog_base=0x1FFE, prog_len=3 -> addresses 0x1FFE, 0x1FFF, 0x000.
REQ-033 SHALL cover: 2nd of 4 words = 16'hE000 (HALT) -> 2 words issued, 2 reads total, done pulse.
REQ-034 SHALL cover: reset=0 with a read outstanding, late imem_rvalid after release -> instr_valid stays 0, FSM in IDLE.
REQ-035 SHALL cover: with ISSUER_OPCODE_CHECK_EN defined, word 16'h4000 -> illegal_op=1, word not issued, done pulse.
